// File: rtl/sys_bus_uart_tx_pkg.sv
// Shared constants for the bus-mapped UART transmitter: bus access encoding,
// register offsets, STATUS bit positions and the serial FSM state type.
package sys_bus_uart_tx_pkg;

    localparam int CPU_WIDTH             = 32;
    localparam int MEM_ACCESS_TYPE_WIDTH = 3;

    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_NONE       = 3'd0;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_BYTE  = 3'd1;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_HALF  = 3'd2;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_WORD  = 3'd3;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_BYTE = 3'd4;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_HALF = 3'd5;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_WORD = 3'd6;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int UART_ST_BUSY      = 0;
    localparam int UART_ST_FULL      = 1;
    localparam int UART_ST_EMPTY     = 2;
    localparam int UART_ST_OVERFLOW  = 3;
    localparam int UART_ST_COUNT_LSB = 8;

    localparam logic [CPU_WIDTH-1:0] UART_BASE_ADDR_DEFAULT = 32'h1000_0000;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic logic is_read_access(input logic [MEM_ACCESS_TYPE_WIDTH-1:0] t);
        return (t == MEM_ACCESS_TYPE_READ_BYTE) || (t == MEM_ACCESS_TYPE_READ_HALF) ||
               (t == MEM_ACCESS_TYPE_READ_WORD);
    endfunction

    function automatic logic is_write_access(input logic [MEM_ACCESS_TYPE_WIDTH-1:0] t);
        return (t == MEM_ACCESS_TYPE_WRITE_BYTE) || (t == MEM_ACCESS_TYPE_WRITE_HALF) ||
               (t == MEM_ACCESS_TYPE_WRITE_WORD);
    endfunction

endpackage

// File: rtl/sys_bus_uart_tx_sync_fifo.sv
// Small show-ahead FIFO: pop_data is the head entry whenever not empty.
// A push while full is accepted only if a pop frees a slot on the same edge.
module sys_bus_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + (AW+1)'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - (AW+1)'(1);
        end
    end

    // Storage carries no reset so it can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/sys_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's system data bus:
// TXDATA pushes into a FIFO, a serial FSM drains it onto txd.
module sys_bus_uart_tx
    import sys_bus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = UART_BASE_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CPU_WIDTH-1:0]             sys_bus_addr_i,
    input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] sys_bus_access_type_i,
    input  logic [CPU_WIDTH-1:0]             sys_bus_wdata_i,
    output logic [CPU_WIDTH-1:0]             sys_bus_rdata_o,
    output logic                             txd,
    output logic                             irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        hit, rd_req, rd_hit, wr_hit, push, pop;
    logic [1:0]  reg_idx;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]  count4;
    logic [15:0] div_eff;
    logic [31:0] status_word, rdata_next;
    logic        unused_bits;

    logic [31:0] rdata_reg;
    logic [15:0] baud_div_reg, div_l_reg, baud_cnt_reg;
    logic        tx_en_reg, irq_en_reg, overflow_reg, txd_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx_reg;
    uart_state_t state_reg;

    assign reg_idx = sys_bus_addr_i[3:2];
    assign hit     = (sys_bus_addr_i[31:4] == BASE_ADDR[31:4]) &&
                     (sys_bus_access_type_i != MEM_ACCESS_TYPE_NONE);
    assign rd_req  = is_read_access(sys_bus_access_type_i);
    assign rd_hit  = hit && rd_req;
    assign wr_hit  = hit && is_write_access(sys_bus_access_type_i);
    assign push    = wr_hit && (reg_idx == UART_TXDATA);
    assign div_eff = (baud_div_reg == 16'd0) ? 16'd1 : baud_div_reg;
    assign unused_bits = ^{sys_bus_addr_i[1:0], sys_bus_wdata_i[31:16]};

    // A new frame loads either from IDLE or at the very end of a stop bit.
    assign pop = tx_en_reg && !fifo_empty &&
                 ((state_reg == UART_IDLE) ||
                  ((state_reg == UART_STOP) && (baud_cnt_reg == 16'd0)));

    sys_bus_uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sys_bus_wdata_i[7:0]),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign count4 = 4'(fifo_count);

    always_comb begin
        status_word = '0;
        status_word[UART_ST_BUSY]     = (state_reg != UART_IDLE);
        status_word[UART_ST_FULL]     = fifo_full;
        status_word[UART_ST_EMPTY]    = fifo_empty;
        status_word[UART_ST_OVERFLOW] = overflow_reg;
        status_word[UART_ST_COUNT_LSB +: 4] = count4;
        case (reg_idx)
            UART_STATUS: rdata_next = status_word;
            UART_BAUD:   rdata_next = {16'd0, baud_div_reg};
            UART_CTRL:   rdata_next = {30'd0, irq_en_reg, tx_en_reg};
            default:     rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg    <= '0;
            baud_div_reg <= DIV_RESET;
            tx_en_reg    <= 1'b0;
            irq_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (rd_req) rdata_reg <= rd_hit ? rdata_next : '0;
            if (wr_hit && reg_idx == UART_BAUD) baud_div_reg <= sys_bus_wdata_i[15:0];
            if (wr_hit && reg_idx == UART_CTRL) begin
                tx_en_reg  <= sys_bus_wdata_i[0];
                irq_en_reg <= sys_bus_wdata_i[1];
            end
            if (push && fifo_full && !pop)
                overflow_reg <= 1'b1;
            else if (wr_hit && reg_idx == UART_STATUS && sys_bus_wdata_i[3])
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= UART_IDLE;
            txd_reg      <= 1'b1;
            baud_cnt_reg <= '0;
            div_l_reg    <= 16'd1;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
        end else if (pop) begin
            shift_reg    <= fifo_dout;
            div_l_reg    <= div_eff;
            baud_cnt_reg <= div_eff - 16'd1;
            txd_reg      <= 1'b0;
            state_reg    <= UART_START;
        end else if (state_reg != UART_IDLE && baud_cnt_reg != 16'd0) begin
            baud_cnt_reg <= baud_cnt_reg - 16'd1;
        end else begin
            baud_cnt_reg <= div_l_reg - 16'd1;
            case (state_reg)
                UART_START: begin
                    txd_reg     <= shift_reg[0];
                    shift_reg   <= {1'b0, shift_reg[7:1]};
                    bit_idx_reg <= '0;
                    state_reg   <= UART_DATA;
                end
                UART_DATA: begin
                    if (bit_idx_reg == 3'd7) begin
                        txd_reg   <= 1'b1;
                        state_reg <= UART_STOP;
                    end else begin
                        txd_reg     <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                    end
                end
                default: begin
                    txd_reg   <= 1'b1;
                    state_reg <= UART_IDLE;
                end
            endcase
        end
    end

    assign sys_bus_rdata_o = rdata_reg;
    assign txd             = txd_reg;
    assign irq_o           = fifo_empty && irq_en_reg;

endmodule

// File: tb/tb_sys_bus_uart_tx.sv
// Directed bench for sys_bus_uart_tx: register access, frame timing,
// overflow, back-to-back frames, async reset and address decode.
module tb_sys_bus_uart_tx;
    import sys_bus_uart_tx_pkg::*;

    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_BAUD   = 32'h1000_0008;
    localparam logic [31:0] A_CTRL   = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [2:0]  acc = MEM_ACCESS_TYPE_NONE;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        txd, irq;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sys_bus_uart_tx #(
        .BASE_ADDR(32'h1000_0000), .FIFO_DEPTH(8), .DIV_RESET(16'd434)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .sys_bus_addr_i        (addr),
        .sys_bus_access_type_i (acc),
        .sys_bus_wdata_i       (wdata),
        .sys_bus_rdata_o       (rdata),
        .txd                   (txd),
        .irq_o                 (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
        @(negedge clk);
        addr = a; acc = t; wdata = d;
        @(negedge clk);
        acc = MEM_ACCESS_TYPE_NONE;
        $display("write addr=0x%08h type=%0d data=0x%08h", a, t, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; acc = MEM_ACCESS_TYPE_READ_WORD;
        @(negedge clk);
        acc = MEM_ACCESS_TYPE_NONE;
        d = rdata;
        $display("read  addr=0x%08h data=0x%08h", a, d);
    endtask

    // Sample txd once per cycle starting the cycle after the enabling write.
    task automatic sample_stream(input string tag, input logic [19:0] stream, input int nbits,
                                 input int div, input int irq_k);
        logic [19:0] s;
        s = stream;
        for (int k = 1; k <= nbits * div; k++) begin
            @(negedge clk);
            check(tag, {31'd0, txd}, {31'd0, s[(k-1)/div]});
            if (irq_k > 0) check({tag, "_irq"}, {31'd0, irq}, {31'd0, k >= irq_k});
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        glitch;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        bus_read(A_STATUS, d); check("rst_status", d, 32'h0000_0004);
        bus_read(A_BAUD, d);   check("rst_baud", d, 32'd434);
        bus_read(A_CTRL, d);   check("rst_ctrl", d, 32'd0);

        // Single A5 frame at div 4, busy checked mid-frame
        bus_write(A_BAUD, MEM_ACCESS_TYPE_WRITE_WORD, 32'd4);
        bus_write(A_CTRL, MEM_ACCESS_TYPE_WRITE_WORD, 32'd1);
        bus_write(A_TXDATA, MEM_ACCESS_TYPE_WRITE_BYTE, 32'h0000_00A5);
        fork
            sample_stream("frame_a5", {10'd0, 1'b1, 8'hA5, 1'b0}, 10, 4, 0);
            begin
                repeat (19) @(negedge clk);
                bus_read(A_STATUS, d);
                check("busy_mid", d & 32'h1, 32'h1);
            end
        join
        bus_read(A_STATUS, d); check("idle_after_a5", d, 32'h0000_0004);

        // Overflow with transmitter disabled
        bus_write(A_CTRL, MEM_ACCESS_TYPE_WRITE_WORD, 32'd0);
        for (int i = 0; i < 9; i++)
            bus_write(A_TXDATA, MEM_ACCESS_TYPE_WRITE_BYTE, 32'h11 * i);
        bus_read(A_STATUS, d); check("full_ovf", d, 32'h0000_080A);
        bus_write(A_STATUS, MEM_ACCESS_TYPE_WRITE_WORD, 32'h8);
        bus_read(A_STATUS, d); check("ovf_clear", d, 32'h0000_0802);

        // Reset during DATA: first byte is 00 so txd is low before reset
        bus_write(A_CTRL, MEM_ACCESS_TYPE_WRITE_WORD, 32'd1);
        repeat (8) @(negedge clk);
        check("txd_pre_rst", {31'd0, txd}, 32'd0);
        #1 rst = 1'b1;
        #1 check("txd_async_rst", {31'd0, txd}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_STATUS, d); check("status_post_rst", d, 32'h0000_0004);
        glitch = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1) glitch = 1'b1;
        end
        check("no_glitch_frame", {31'd0, glitch}, 32'd0);

        // Back-to-back frames at div 2 with irq
        bus_write(A_CTRL, MEM_ACCESS_TYPE_WRITE_WORD, 32'd2);
        check("irq_empty", {31'd0, irq}, 32'd1);
        bus_write(A_TXDATA, MEM_ACCESS_TYPE_WRITE_BYTE, 32'h3C);
        bus_write(A_TXDATA, MEM_ACCESS_TYPE_WRITE_HALF, 32'hC3);
        check("irq_nonempty", {31'd0, irq}, 32'd0);
        bus_write(A_BAUD, MEM_ACCESS_TYPE_WRITE_WORD, 32'd2);
        bus_write(A_CTRL, MEM_ACCESS_TYPE_WRITE_WORD, 32'd3);
        sample_stream("b2b", {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}, 20, 2, 21);
        bus_read(A_STATUS, d); check("idle_after_b2b", d, 32'h0000_0004);

        // Decode: out-of-window and NONE accesses change nothing
        bus_write(32'h1000_0018, MEM_ACCESS_TYPE_WRITE_WORD, 32'h99);
        @(negedge clk);
        addr = A_BAUD; acc = MEM_ACCESS_TYPE_NONE; wdata = 32'h77;
        @(negedge clk);
        bus_read(A_BAUD, d); check("baud_unchanged", d, 32'd2);
        bus_write(A_CTRL, MEM_ACCESS_TYPE_WRITE_WORD, 32'd0);
        check("rdata_hold_on_write", rdata, 32'd2);
        @(negedge clk);
        addr = A_STATUS; acc = MEM_ACCESS_TYPE_NONE;
        @(negedge clk);
        check("rdata_hold_on_none", rdata, 32'd2);
        bus_read(32'h1000_0010, d); check("miss_read", d, 32'd0);
        bus_read(A_TXDATA, d); check("txdata_read", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
